// File: rtl/mem_pkg.sv
// Shared encodings for the data memory responder: funct3 sizes and FSM states.
package mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_WAIT   = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;
    localparam logic [1:0] ST_RESP   = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = ST_IDLE,
        WAIT   = ST_WAIT,
        ACCESS = ST_ACCESS,
        RESP   = ST_RESP
    } state_e;

    // Loads accept b/h/w/bu/hu; stores only b/h/w.
    function automatic logic f3_legal(input logic [2:0] f3, input logic we);
        case (f3)
            F3_B, F3_H, F3_W: f3_legal = 1'b1;
            F3_BU, F3_HU:     f3_legal = ~we;
            default:          f3_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/load_align.sv
// Selects the byte/half/word addressed by lane and sign- or zero-extends it.
module load_align
    import mem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  lane,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);

    logic [7:0]  sel_b;
    logic [15:0] sel_h;

    // Lane selection and extension.
    always_comb begin
        sel_b  = word[{lane, 3'b000} +: 8];
        sel_h  = lane[1] ? word[31:16] : word[15:0];
        result = '0;
        case (funct3)
            F3_B:    result = {{24{sel_b[7]}}, sel_b};
            F3_H:    result = {{16{sel_h[15]}}, sel_h};
            F3_W:    result = word;
            F3_BU:   result = {24'd0, sel_b};
            F3_HU:   result = {16'd0, sel_h};
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// Load/store responder: one request at a time, fixed wait, then a single-cycle
// byte/half/word access on a local word array, result held until accepted.
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 64,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_funct3,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int unsigned CW = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);
    localparam int unsigned IW = (DEPTH_WORDS < 2) ? 1 : $clog2(DEPTH_WORDS);

    state_e         state;
    logic [CW-1:0]  cnt;
    logic           we_q;
    logic [31:0]    addr_q;
    logic [31:0]    wdata_q;
    logic [2:0]     f3_q;

    logic [31:0]    mem [DEPTH_WORDS];

    logic           misaligned;
    logic           out_of_range;
    logic           acc_err;
    logic [IW-1:0]  idx;
    logic [31:0]    rd_word;
    logic [31:0]    ld_result;
    logic [3:0]     lane_mask;
    logic [31:0]    wr_data;
    logic           wr_en;

    // Error evaluation, lane mask and write data for the latched request.
    always_comb begin
        idx          = addr_q[IW+1:2];
        out_of_range = addr_q[31:2] >= 30'(DEPTH_WORDS);
        misaligned   = 1'b0;
        lane_mask    = 4'b0000;
        wr_data      = wdata_q;
        case (f3_q)
            F3_H, F3_HU: misaligned = addr_q[0];
            F3_W:        misaligned = addr_q[1] | addr_q[0];
            default:     misaligned = 1'b0;
        endcase
        case (f3_q)
            F3_B: begin
                lane_mask = 4'b0001 << addr_q[1:0];
                wr_data   = {4{wdata_q[7:0]}};
            end
            F3_H: begin
                lane_mask = addr_q[1] ? 4'b1100 : 4'b0011;
                wr_data   = {2{wdata_q[15:0]}};
            end
            F3_W:    lane_mask = 4'b1111;
            default: lane_mask = 4'b0000;
        endcase
        acc_err = misaligned | out_of_range | ~f3_legal(f3_q, we_q);
        wr_en   = (state == ACCESS) & we_q & ~acc_err;
        rd_word = out_of_range ? 32'd0 : mem[idx];
    end

    load_align u_load_align (
        .word   (rd_word),
        .lane   (addr_q[1:0]),
        .funct3 (f3_q),
        .result (ld_result)
    );

    // Storage array: not reset, written only by a legal store in ACCESS.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (wr_en && lane_mask[i]) begin
                mem[idx][8*i +: 8] <= wr_data[8*i +: 8];
            end
        end
    end

    // Request/response FSM with registered handshake and response outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            f3_q      <= F3_W;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        we_q      <= req_we;
                        addr_q    <= req_addr;
                        wdata_q   <= req_wdata;
                        f3_q      <= req_funct3;
                        cnt       <= CW'(WAIT_CYCLES);
                        req_ready <= 1'b0;
                        state     <= (WAIT_CYCLES == 0) ? ACCESS : WAIT;
                    end
                end
                WAIT: begin
                    cnt <= cnt - CW'(1);
                    if (cnt <= CW'(1)) begin
                        state <= ACCESS;
                    end
                end
                ACCESS: begin
                    rsp_rdata <= (acc_err || we_q) ? 32'd0 : ld_result;
                    rsp_err   <= acc_err;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench: DUT 0 with WAIT_CYCLES=2, DUT 1 with WAIT_CYCLES=0.
module tb_data_mem_responder;
    import mem_pkg::*;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid  [2];
    logic        req_ready  [2];
    logic        req_we     [2];
    logic [31:0] req_addr   [2];
    logic [31:0] req_wdata  [2];
    logic [2:0]  req_funct3 [2];
    logic        rsp_valid  [2];
    logic        rsp_ready  [2];
    logic [31:0] rsp_rdata  [2];
    logic        rsp_err    [2];

    exp_t sb_q [$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    data_mem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_funct3(req_funct3[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
    );

    data_mem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_funct3(req_funct3[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic timeout(input string tag);
        n_fail++;
        $display("FAIL %s timeout", tag);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $fatal(1, "bench stopped");
    endtask

    // Drive one request, check latency, optional backpressure, then the scoreboard result.
    task automatic transact(input bit s, input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [2:0] f3,
                            input logic [31:0] exp_rd, input logic exp_err,
                            input int hold, input string tag);
        exp_t        e;
        int          lat;
        logic [31:0] first;
        bit          ok;
        e.rdata = exp_rd;
        e.err   = exp_err;
        sb_q.push_back(e);
        @(negedge clk);
        req_we[s] = we; req_addr[s] = addr; req_wdata[s] = wdata; req_funct3[s] = f3;
        req_valid[s] = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (req_ready[s]) ok = 1'b1;
            else @(negedge clk);
        end
        if (!ok) timeout({tag, "_accept"});
        @(posedge clk);
        #1;
        req_valid[s] = 1'b0;
        req_we[s] = 1'b1; req_addr[s] = 32'h0; req_wdata[s] = 32'hFFFF_FFFF; req_funct3[s] = F3_W;
        check({tag, "_rdy_low"}, 32'(req_ready[s]), 32'd0);
        lat = 0;
        while (!rsp_valid[s] && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!rsp_valid[s]) timeout({tag, "_rsp"});
        check({tag, "_lat"}, 32'(lat), (s == 1'b0) ? 32'd3 : 32'd1);
        first = rsp_rdata[s];
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, "_hold_valid"}, 32'(rsp_valid[s]), 32'd1);
            check({tag, "_hold_rdata"}, rsp_rdata[s], first);
            check({tag, "_hold_rdy"}, 32'(req_ready[s]), 32'd0);
        end
        @(negedge clk);
        rsp_ready[s] = 1'b1;
        e = sb_q.pop_front();
        check({tag, "_rdata"}, rsp_rdata[s], e.rdata);
        check({tag, "_err"}, 32'(rsp_err[s]), 32'(e.err));
        @(posedge clk);
        #1;
        rsp_ready[s] = 1'b0;
        check({tag, "_valid_drop"}, 32'(rsp_valid[s]), 32'd0);
        check({tag, "_rdy_back"}, 32'(req_ready[s]), 32'd1);
    endtask

    // Start sw 0x12345678 @0x30 and reset before the access happens.
    task automatic reset_store(input bit s, input string tag);
        @(negedge clk);
        req_we[s] = 1'b1; req_addr[s] = 32'h30; req_wdata[s] = 32'h1234_5678; req_funct3[s] = F3_W;
        req_valid[s] = 1'b1;
        if (!req_ready[s]) timeout({tag, "_accept"});
        @(posedge clk);
        #1;
        req_valid[s] = 1'b0;
        if (s == 1'b0) begin
            @(posedge clk);
            #1;
        end
        check({tag, "_busy"}, 32'(req_ready[s]), 32'd0);
        #1 rst_n = 1'b0;
        #1;
        check({tag, "_rst_valid"}, 32'(rsp_valid[s]), 32'd0);
        check({tag, "_rst_rdy"}, 32'(req_ready[s]), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            req_valid[i] = 1'b0; req_we[i] = 1'b0; req_addr[i] = '0;
            req_wdata[i] = '0; req_funct3[i] = F3_W; rsp_ready[i] = 1'b0;
        end
        @(negedge clk);
        @(negedge clk);
        check("reset_rdy", 32'(req_ready[0]), 32'd1);
        check("reset_valid", 32'(rsp_valid[0]), 32'd0);
        check("reset_rdata", rsp_rdata[0], 32'd0);
        check("reset_err", 32'(rsp_err[0]), 32'd0);
        check("reset_rdy0", 32'(req_ready[1]), 32'd1);
        rst_n = 1'b1;

        transact(1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, F3_W,  32'h0,         1'b0, 0, "sw_10");
        transact(1'b0, 1'b0, 32'h10, 32'h0,         F3_W,  32'hDEAD_BEEF, 1'b0, 0, "lw_10");
        transact(1'b0, 1'b1, 32'h11, 32'h1234_5680, F3_B,  32'h0,         1'b0, 0, "sb_11");
        transact(1'b0, 1'b0, 32'h11, 32'h0,         F3_B,  32'hFFFF_FF80, 1'b0, 0, "lb_11");
        transact(1'b0, 1'b0, 32'h11, 32'h0,         F3_BU, 32'h0000_0080, 1'b0, 0, "lbu_11");
        transact(1'b0, 1'b0, 32'h10, 32'h0,         F3_W,  32'hDEAD_80EF, 1'b0, 0, "lw_10b");
        transact(1'b0, 1'b1, 32'h20, 32'h1357_2468, F3_W,  32'h0,         1'b0, 0, "sw_20");
        transact(1'b0, 1'b1, 32'h22, 32'hABCD_8001, F3_H,  32'h0,         1'b0, 0, "sh_22");
        transact(1'b0, 1'b0, 32'h22, 32'h0,         F3_H,  32'hFFFF_8001, 1'b0, 0, "lh_22");
        transact(1'b0, 1'b0, 32'h22, 32'h0,         F3_HU, 32'h0000_8001, 1'b0, 0, "lhu_22");
        transact(1'b0, 1'b0, 32'h20, 32'h0,         F3_W,  32'h8001_2468, 1'b0, 0, "lw_20");

        transact(1'b0, 1'b1, 32'h00, 32'h1122_3344, F3_W,   32'h0, 1'b0, 0, "sw_00");
        transact(1'b0, 1'b0, 32'h02, 32'h0,         F3_W,   32'h0, 1'b1, 0, "err_lw_02");
        transact(1'b0, 1'b1, 32'h03, 32'hFFFF_FFFF, F3_H,   32'h0, 1'b1, 0, "err_sh_03");
        transact(1'b0, 1'b0, 32'h100, 32'h0,        F3_W,   32'h0, 1'b1, 0, "err_lw_100");
        transact(1'b0, 1'b0, 32'h00, 32'h0,         3'b011, 32'h0, 1'b1, 0, "err_f3_011");
        transact(1'b0, 1'b1, 32'h00, 32'hFFFF_FFFF, F3_BU,  32'h0, 1'b1, 0, "err_sbu");
        transact(1'b0, 1'b0, 32'h00, 32'h0,         F3_W,   32'h1122_3344, 1'b0, 0, "lw_00_clean");

        transact(1'b0, 1'b0, 32'h10, 32'h0, F3_W, 32'hDEAD_80EF, 1'b0, 4, "hold_lw");

        transact(1'b0, 1'b1, 32'h30, 32'hCAFE_F00D, F3_W, 32'h0, 1'b0, 0, "sw_30");
        reset_store(1'b0, "rst_wait");
        transact(1'b0, 1'b0, 32'h30, 32'h0, F3_W, 32'hCAFE_F00D, 1'b0, 0, "lw_30_kept");

        transact(1'b1, 1'b1, 32'h30, 32'h0BAD_C0DE, F3_W, 32'h0,         1'b0, 0, "z_sw_30");
        transact(1'b1, 1'b0, 32'h30, 32'h0,         F3_W, 32'h0BAD_C0DE, 1'b0, 0, "z_lw_30");
        transact(1'b1, 1'b0, 32'h33, 32'h0,         F3_B, 32'h0000_000B, 1'b0, 0, "z_lb_33");
        transact(1'b1, 1'b0, 32'h30, 32'h0,         F3_H, 32'hFFFF_C0DE, 1'b0, 2, "z_lh_30");
        reset_store(1'b1, "z_rst");
        transact(1'b1, 1'b0, 32'h30, 32'h0, F3_W, 32'h0BAD_C0DE, 1'b0, 0, "z_lw_30_kept");
        transact(1'b0, 1'b0, 32'h30, 32'h0, F3_W, 32'hCAFE_F00D, 1'b0, 0, "lw_30_after_z");

        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
